upload_packer: RTL and testbench
================================

Name: upload_packer

Overview:
- Downstream end of the merged upload interface: the responder that consumes the arbiter's req/data/source/valid stream.
- Collects each contiguous same-source byte run into a local payload buffer.
- Emits one framed packet per run on a byte-wide valid/ready TX stream toward the USB/UART host link.
- Frame format: header 0xAA 0x44, source, 16-bit length (big-endian), payload, optional checksum.

Parameters:
- MAX_PAYLOAD, 256, payload buffer depth and maximum bytes per frame (1..65535).
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h44, second header byte.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- upload_req  in  1  packet-in-progress flag from arbiter.
- upload_data  in  8  payload byte.
- upload_source  in  8  source ID of the byte.
- upload_valid  in  1  byte valid.
- upload_ready  out  1  packer can accept a byte.
- tx_data  out  8  framed output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host link accepts byte.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; count=0; cur_src=0; csum=0; tx_data=0; tx_valid=0; busy=0; buffer contents don't-care.
- Input handshake: byte accepted on a clk edge with upload_valid && upload_ready.
- upload_ready is combinational: (state==IDLE) || (state==COLLECT && count<MAX_PAYLOAD && !(upload_valid && upload_source!=cur_src)). It is 0 in every TX state.
- States: IDLE, COLLECT, T_HDR0, T_HDR1, T_SRC, T_LENH, T_LENL, T_PAY, T_CSUM.
- IDLE: on accept, store byte at buf[0], latch cur_src=upload_source, count=1, csum=upload_source+byte → COLLECT. If that beat has upload_req=0 → T_HDR0 directly with count=1.
- COLLECT: on accept, buf[count]=byte, count+1, csum+=byte.
- COLLECT close conditions, evaluated after any accept in the same cycle; any true → T_HDR0:
  - accepted beat had upload_req=0 (beat included in the frame);
  - upload_req=0 with no valid;
  - upload_valid with a different source (that byte is left pending, not accepted);
  - count reaches MAX_PAYLOAD.
- Entering T_HDR0: csum+=len_hi+len_lo.
- TX: each T_ state presents its byte with tx_valid=1.
  - tx_data/tx_valid are registered and held stable while tx_valid && !tx_ready.
  - Advance on tx_valid && tx_ready.
  - Order: HDR0, HDR1, cur_src, count[15:8], count[7:0], buf[0..count-1], checksum.
  - Back-to-back bytes allowed (one byte per cycle when tx_ready is held high).
- T_PAY uses a read index 0..count-1. After the last byte: → T_CSUM if checksum is enabled, else → IDLE.
- T_CSUM: tx_data = csum (mod 256 sum of source, len_hi, len_lo, all payload bytes). Advance → IDLE with count cleared.
- Pending different-source byte: accepted in IDLE after the frame completes (at least one cycle gap), starting a new frame.
- Widths: count and length are 16 bits; csum is 8-bit wrap-around.
- Boundary cases:
  - count=MAX_PAYLOAD closes the frame even with upload_req still high; subsequent same-source bytes form a new frame.
  - Length 0 is never emitted.
- Reset mid-frame: frame aborted, tx_valid drops asynchronously, partial frame is not resumed.

Optional Feature:
- Macro: UPLOAD_PACKER_CHECKSUM_EN.
- Defined: T_CSUM state present; frame ends with the checksum byte; frame length = 5+N+1.
- Undefined: no csum register, no T_CSUM state; T_PAY last byte → IDLE; frame length = 5+N.

Test Plan:
- Source 0x03, bytes 11 22 33, upload_req high throughout, then low; tx_ready=1 → TX AA 44 03 00 03 11 22 33 6C; upload_ready=0 during TX; busy returns to 0.
- Source 0x01 bytes A0 A1 then source 0x02 byte B0 with no req gap → frame AA 44 01 00 02 A0 A1 44 completes first; B0 held (upload_ready=0) until IDLE, then frame AA 44 02 00 01 B0 B3.
- MAX_PAYLOAD=4, source 0x05 sends 6 bytes 00..05 with req high → frames of length 4 (00..03) then length 2 (04 05), each with correct checksum.
- tx_ready toggled 1/0 pseudo-randomly during a 3-byte frame → tx_data stable on every stall cycle; the output byte sequence is identical to the no-stall run.
- Single beat in IDLE with upload_req=0, source 0x07, data 0xFF → AA 44 07 00 01 FF 07.
- Assert rst_n=0 during T_PAY, then release and send source 0x03 byte 0x10 → next output is a clean frame AA 44 03 00 01 10 14 with no residue from the aborted frame.
- Rerun the above scenarios with UPLOAD_PACKER_CHECKSUM_EN undefined → identical frames minus the trailing byte.

Source files
------------

// File: rtl/upload_packer.sv
// Frames each contiguous same-source upload run as AA 44 src lenH lenL payload [csum] on a byte TX stream.
// Define UPLOAD_PACKER_CHECKSUM_EN to append the mod-256 checksum byte to every frame.
module upload_packer #(
    parameter int          MAX_PAYLOAD = 256,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h44
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upload_req,
    input  logic [7:0] upload_data,
    input  logic [7:0] upload_source,
    input  logic       upload_valid,
    output logic       upload_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);
    localparam int          AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        IDLE, COLLECT, T_HDR0, T_HDR1, T_SRC, T_LENH, T_LENL, T_PAY
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        , T_CSUM
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] rd_idx_q, rd_idx_d;
    logic [7:0]  cur_src_q;
    logic [7:0]  tx_byte_d;
    logic        tx_vld_d;
    logic [7:0]  pay_mem [MAX_PAYLOAD];
    logic [AW-1:0] wr_idx;

    logic accept, src_change, tx_fire, pay_last;

    assign accept     = upload_valid && upload_ready;
    assign src_change = upload_valid && (upload_source != cur_src_q);
    assign tx_fire    = tx_valid && tx_ready;
    assign pay_last   = (rd_idx_q == count_q - 16'd1);
    assign wr_idx     = (state_q == IDLE) ? '0 : count_q[AW-1:0];

`ifdef UPLOAD_PACKER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Length bytes are folded in on the single cycle that enters T_HDR0.
    always_comb begin
        csum_d = csum_q;
        if (accept)
            csum_d = (state_q == IDLE) ? upload_source + upload_data : csum_q + upload_data;
        if (state_d == T_HDR0 && state_q != T_HDR0)
            csum_d = csum_d + count_d[15:8] + count_d[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= 8'h00;
        else        csum_q <= csum_d;
    end
`endif

    // State register plus the registered TX byte, so tx_data holds across stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= 16'd0;
            rd_idx_q  <= 16'd0;
            cur_src_q <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            tx_data  <= tx_byte_d;
            tx_valid <= tx_vld_d;
            if (state_q == IDLE && accept)
                cur_src_q <= upload_source;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pay_mem[wr_idx] <= upload_data;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    count_d = 16'd1;
                    state_d = (upload_req && MAX_LEN != 16'd1) ? COLLECT : T_HDR0;
                end
            end
            COLLECT: begin
                if (accept)
                    count_d = count_q + 16'd1;
                if ((accept && !upload_req) || (!upload_valid && !upload_req) ||
                    src_change || count_d == MAX_LEN)
                    state_d = T_HDR0;
            end
            T_HDR0: if (tx_fire) state_d = T_HDR1;
            T_HDR1: if (tx_fire) state_d = T_SRC;
            T_SRC:  if (tx_fire) state_d = T_LENH;
            T_LENH: if (tx_fire) state_d = T_LENL;
            T_LENL: begin
                if (tx_fire) begin
                    state_d  = T_PAY;
                    rd_idx_d = 16'd0;
                end
            end
            T_PAY: begin
                if (tx_fire) begin
                    if (pay_last) begin
`ifdef UPLOAD_PACKER_CHECKSUM_EN
                        state_d = T_CSUM;
`else
                        state_d = IDLE;
                        count_d = 16'd0;
`endif
                    end else begin
                        rd_idx_d = rd_idx_q + 16'd1;
                    end
                end
            end
`ifdef UPLOAD_PACKER_CHECKSUM_EN
            T_CSUM: begin
                if (tx_fire) begin
                    state_d = IDLE;
                    count_d = 16'd0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Byte for the state being entered; registered above.
    always_comb begin
        tx_byte_d    = 8'h00;
        tx_vld_d     = (state_d != IDLE) && (state_d != COLLECT);
        busy         = (state_q != IDLE);
        upload_ready = (state_q == IDLE) ||
                       (state_q == COLLECT && count_q < MAX_LEN && !src_change);
        case (state_d)
            T_HDR0: tx_byte_d = HDR0;
            T_HDR1: tx_byte_d = HDR1;
            T_SRC:  tx_byte_d = cur_src_q;
            T_LENH: tx_byte_d = count_q[15:8];
            T_LENL: tx_byte_d = count_q[7:0];
            T_PAY:  tx_byte_d = pay_mem[rd_idx_d[AW-1:0]];
`ifdef UPLOAD_PACKER_CHECKSUM_EN
            T_CSUM: tx_byte_d = csum_q;
`endif
            default: tx_byte_d = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_upload_packer.sv
// Scoreboard bench for upload_packer: expected frame bytes queued by stimulus, popped by a TX monitor.
module tb_upload_packer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       stall_en = 1'b0;
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic [7:0] e_byte;

    upload_packer #(.MAX_PAYLOAD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .upload_req(upload_req), .upload_data(upload_data),
        .upload_source(upload_source), .upload_valid(upload_valid),
        .upload_ready(upload_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial tx_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] src, input int n,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] cs);
        logic [7:0] p[4];
        p[0] = b0; p[1] = b1; p[2] = b2; p[3] = b3;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h44);
        exp_q.push_back(src);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) exp_q.push_back(p[i]);
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        exp_q.push_back(cs);
`else
        if (cs == 8'h00) exp_q.push_back(8'h00); // never taken: no frame here has a zero checksum
`endif
    endtask

    task automatic beat(input logic [7:0] s, input logic [7:0] d, input logic r, output int waited);
        int n = 0;
        upload_valid  = 1'b1;
        upload_source = s;
        upload_data   = d;
        upload_req    = r;
        @(negedge clk);
        while (!upload_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("beat_timeout", 16'(n), 16'd0);
        waited = n;
        @(posedge clk);
        #1;
        upload_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({nm, "_drain_timeout"}, 16'(exp_q.size()), 16'd0);
        @(posedge clk);
        #1;
        chk({nm, "_busy_idle"}, 16'(busy), 16'd0);
        chk({nm, "_txv_idle"}, 16'(tx_valid), 16'd0);
    endtask

    // Monitor: stall stability, upload_ready low during TX, and byte order.
    initial begin
        forever begin
            @(negedge clk);
            if (held_v) begin
                chk("stall_valid", 16'(tx_valid), 16'd1);
                chk("stall_data", 16'(tx_data), 16'(held_d));
            end
            held_v = rst_n && tx_valid && !tx_ready;
            held_d = tx_data;
            if (rst_n && tx_valid) begin
                chk("ready_low_in_tx", 16'(upload_ready), 16'd0);
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx_byte", 16'(tx_data), 16'hFFFF);
                    end else begin
                        e_byte = exp_q.pop_front();
                        chk("tx_byte", 16'(tx_data), 16'(e_byte));
                    end
                end
            end
        end
    end

    initial begin
        int w;
        int rem;
        int n;
        rst_n = 1'b0;
        upload_req = 1'b0; upload_valid = 1'b0;
        upload_data = 8'h00; upload_source = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 16'(tx_valid), 16'd0);
        chk("rst_tx_data", 16'(tx_data), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_upload_ready", 16'(upload_ready), 16'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic 3-byte run
        push_frame(8'h03, 3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h6C);
        beat(8'h03, 8'h11, 1'b1, w);
        beat(8'h03, 8'h22, 1'b1, w);
        beat(8'h03, 8'h33, 1'b1, w);
        upload_req = 1'b0;
        drain("s1");

        // source switch without req gap: B0 held until IDLE
        push_frame(8'h01, 2, 8'hA0, 8'hA1, 8'h00, 8'h00, 8'h44);
        push_frame(8'h02, 1, 8'hB0, 8'h00, 8'h00, 8'h00, 8'hB3);
        beat(8'h01, 8'hA0, 1'b1, w);
        beat(8'h01, 8'hA1, 1'b1, w);
        beat(8'h02, 8'hB0, 1'b1, w);
        chk("s2_b0_held", 16'(w > 0), 16'd1);
        upload_req = 1'b0;
        drain("s2");

        // MAX_PAYLOAD=4 split with req held high
        push_frame(8'h05, 4, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0F);
        push_frame(8'h05, 2, 8'h04, 8'h05, 8'h00, 8'h00, 8'h10);
        for (int i = 0; i < 6; i++) begin
            beat(8'h05, 8'(i), 1'b1, w);
            if (i == 4) chk("s3_split_held", 16'(w > 0), 16'd1);
        end
        upload_req = 1'b0;
        drain("s3");

        // random tx_ready stalls
        stall_en = 1'b1;
        push_frame(8'h09, 3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h12);
        beat(8'h09, 8'h01, 1'b1, w);
        beat(8'h09, 8'h02, 1'b1, w);
        beat(8'h09, 8'h03, 1'b1, w);
        upload_req = 1'b0;
        drain("s4");
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        // single beat straight from IDLE with req low
        push_frame(8'h07, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h07);
        beat(8'h07, 8'hFF, 1'b0, w);
        drain("s5");

        // reset during payload transmission
        push_frame(8'h0A, 3, 8'h55, 8'h66, 8'h77, 8'h00, 8'h3F);
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        rem = 3;
`else
        rem = 2;
`endif
        beat(8'h0A, 8'h55, 1'b1, w);
        beat(8'h0A, 8'h66, 1'b1, w);
        beat(8'h0A, 8'h77, 1'b1, w);
        upload_req = 1'b0;
        n = 0;
        while (exp_q.size() > rem && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("s6_pay_timeout", 16'(exp_q.size()), 16'(rem));
        #2;
        chk("s6_in_pay_txv", 16'(tx_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_txv_async", 16'(tx_valid), 16'd0);
        chk("s6_rst_busy", 16'(busy), 16'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_frame(8'h03, 1, 8'h10, 8'h00, 8'h00, 8'h00, 8'h14);
        beat(8'h03, 8'h10, 1'b0, w);
        drain("s6");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
